wca_signal_debounce: RTL and testbench

WCA_SIGNAL_DEBOUNCE -- requirements
Module: wca_signal_debounce

---
 rtl/wca_signal_debounce_if.sv | 39 +++
 rtl/wca_signal_debounce.sv | 140 ++++++++++++++
 tb/tb_wca_signal_debounce.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wca_signal_debounce_if.sv
`default_nettype none
// ============================================================================
// Module   : wca_signal_debounce_if
// Purpose  : Groups the sample-side and result-side signals of the debouncer.
//            ena   - sample enable (driven by master)
//            in    - raw level to be debounced (driven by master)
//            level - debounced level (driven by slave)
//            rise  - one-cycle 0->1 pulse (driven by slave)
//            fall  - one-cycle 1->0 pulse (driven by slave)
//            busy  - candidate transition being qualified (driven by slave)
// Revision : 1.0 - initial release
// ============================================================================
interface wca_signal_debounce_if;
    logic ena;
    logic in;
    logic level;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output ena,
        output in,
        input  level,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  ena,
        input  in,
        output level,
        output rise,
        output fall,
        output busy
    );
endinterface : wca_signal_debounce_if
`default_nettype wire

// File: rtl/wca_signal_debounce.sv
`default_nettype none
// ============================================================================
// Module   : wca_signal_debounce
// Purpose  : Debounces a single-bit level. A new level is accepted only after
//            HOLD_COUNT consecutive enabled samples at that level; a shorter
//            excursion is discarded as a glitch. Emits registered one-cycle
//            rise/fall pulses on every accepted change.
// Ports    : clk   - clock, all logic on rising edge
//            reset - synchronous active-high reset (priority over all inputs)
//            dbif  - wca_signal_debounce_if.slave (ena, in, level, rise,
//                    fall, busy)
// Params   : HOLD_COUNT - samples needed to accept a new level (2..255)
//            CNT_WIDTH  - hold counter width, 2**CNT_WIDTH > HOLD_COUNT
// Config   : WCA_DEBOUNCE_SYNC_EN - when defined, in passes through an
//            internal two-flop synchronizer first (adds 2 cycles latency).
// Revision : 1.0 - initial release
// ============================================================================
module wca_signal_debounce #(
    parameter int HOLD_COUNT = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    wca_signal_debounce_if.slave dbif
);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(HOLD_COUNT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_level;
    logic                 w_level_nxt;
    logic                 r_rise;
    logic                 w_rise_nxt;
    logic                 r_fall;
    logic                 w_fall_nxt;
    logic                 r_busy;
    logic                 w_sample;

`ifdef WCA_DEBOUNCE_SYNC_EN
    // The synchronizer runs regardless of ena: it only resolves metastability
    // and must keep tracking the pin so that no stale value is released
    // when sampling resumes.
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dbif.in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = dbif.in;
`endif

    // Next-state / output decode. With ena low every register keeps its
    // value except the pulses, which default to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        if (dbif.ena) begin
            case (r_state)
                ST_STABLE: begin
                    if (w_sample != r_level) begin
                        // This sample is the first of the HOLD_COUNT run.
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = c_cnt_one;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                ST_CHECK: begin
                    if (w_sample == r_level) begin
                        // Excursion ended early: glitch, discard silently.
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_cnt_last) begin
                        // '>=' rather than '==' keeps the counter bounded
                        // even if it were ever corrupted above the limit.
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = w_sample;
                        w_rise_nxt  = w_sample;
                        w_fall_nxt  = ~w_sample;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            // Registered copy of (state == CHECK), aligned with r_state.
            r_busy  <= (w_state_nxt == ST_CHECK);
        end
    end

    assign dbif.level = r_level;
    assign dbif.rise  = r_rise;
    assign dbif.fall  = r_fall;
    assign dbif.busy  = r_busy;

endmodule : wca_signal_debounce
`default_nettype wire

// File: tb/tb_wca_signal_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_wca_signal_debounce
// Purpose  : Self-checking bench for wca_signal_debounce. Stimulus pushes the
//            expected {level,rise,fall,busy} for each clock into a queue; a
//            monitor pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wca_signal_debounce;

    localparam int HOLD = 4;
    localparam int CW   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    wca_signal_debounce_if dbif ();

    wca_signal_debounce #(
        .HOLD_COUNT (HOLD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbif  (dbif)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];

    // Reference model: the accepted level and the number of consecutive
    // enabled samples seen at the opposite level.
    logic m_level = 1'b0;
    int   m_run   = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;

    task automatic step(input logic r, input logic e, input logic din);
        logic       smp;
        logic       rs;
        logic       fl;
        logic [3:0] expv;
        @(negedge clk);
        reset    = r;
        dbif.ena = e;
        dbif.in  = din;
`ifdef WCA_DEBOUNCE_SYNC_EN
        smp = m_s2;
`else
        smp = din;
`endif
        rs = 1'b0;
        fl = 1'b0;
        if (r) begin
            m_level = 1'b0;
            m_run   = 0;
        end else if (e) begin
            if (smp != m_level) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_level = smp;
                    rs      = smp;
                    fl      = ~smp;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
`ifdef WCA_DEBOUNCE_SYNC_EN
        if (r) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            m_s2 = m_s1;
            m_s1 = din;
        end
`endif
        expv = {m_level, rs, fl, (m_run != 0)};
        exp_q.push_back(expv);
    endtask

    // Monitor: one observation per clock, checked against the queue head.
    initial begin : p_monitor
        logic [3:0] expv;
        logic [3:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                act  = {dbif.level, dbif.rise, dbif.fall, dbif.busy};
                n_cmp++;
                if (act !== expv) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t level/rise/fall/busy got %b want %b",
                             $time, act, expv);
                end
                n_cmp++;
                if (dut.r_cnt > CW'(HOLD - 1)) begin
                    n_bad++;
                    $display("FAIL cnt_bound t=%0t cnt got %0d want <= %0d",
                             $time, dut.r_cnt, HOLD - 1);
                end
            end
        end
    end

    initial begin : p_stim
        logic cur;
        dbif.ena = 1'b0;
        dbif.in  = 1'b0;

        // Reset, then in held high: level rises after the 4th sample.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1);

        // Glitch low for 3 samples: no fall.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1);

        // Real fall, then ena gap in the middle of a rise qualification.
        repeat (6) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        repeat (4) step(1'b0, 1'b1, 1'b1);

        // Reset in the middle of a qualification with in held high.
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1, 1'b1);

        // Alternating input: never qualifies.
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b1, (k % 2 == 0));

        // Randomised: runs of varying length, occasional ena gaps and resets.
        cur = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) cur = ~cur;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 cur);
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wca_signal_debounce
`default_nettype wire
